// File: rtl/arch_reg_dump_if.sv
// Dump stream port of arch_reg_dump_unit. Each beat carries a register index and its value.
// A beat transfers when valid and ready are both high in the same cycle.
interface arch_reg_dump_if #(
    parameter int AW         = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [AW-1:0]         idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, idx, data, last, input ready);
    modport slave  (input valid, idx, data, last, output ready);
endinterface

// File: rtl/arch_reg_dump_unit.sv
// Counts CPU run cycles until finish or watchdog expiry, then reads every architectural
// register through the ARCH_REG_READ port and streams {index, value} beats out.
module arch_reg_dump_unit #(
    parameter int NUM_ARCH_REGS  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LAT         = 1,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int AW = (NUM_ARCH_REGS > 1) ? $clog2(NUM_ARCH_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cpu_finish,
    output logic [AW-1:0]         o_arch_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_arch_rd_data,
    arch_reg_dump_if.master       dump,
    output logic [CNT_WIDTH-1:0]  o_cycle_count,
    output logic                  o_timeout,
    output logic                  o_done
);
    typedef enum logic [2:0] {S_RUN, S_ISSUE, S_WAIT, S_SEND, S_DONE} state_t;

    localparam logic [AW-1:0]        LAST_IDX = AW'(NUM_ARCH_REGS - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [1:0]           LAT      = 2'(RD_LAT);

    state_t                r_state;
    logic [AW-1:0]         r_idx;
    logic [AW-1:0]         r_addr;
    logic [AW-1:0]         r_dump_idx;
    logic [DATA_WIDTH-1:0] r_dump_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_timeout;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [1:0]            r_lat_cnt;

    logic w_xfer;
    logic w_idx_last;
    logic w_capture;

    assign w_xfer     = r_valid & dump.ready;
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_capture  = ((r_state == S_ISSUE) && (RD_LAT == 0)) ||
                        ((r_state == S_WAIT) && (r_lat_cnt == LAT));

    // The read address always tracks idx, so it is already stable in the ISSUE cycle;
    // that lets a combinational regfile (RD_LAT=0) be captured without a WAIT state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_idx       <= '0;
            r_addr      <= '0;
            r_dump_idx  <= '0;
            r_dump_data <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_lat_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_cpu_finish) begin
                        r_state <= S_ISSUE;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                S_ISSUE: begin
                    r_addr    <= r_idx;
                    r_lat_cnt <= 2'd1;
                    r_state   <= (RD_LAT == 0) ? S_SEND : S_WAIT;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (r_lat_cnt == LAT) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        if (w_idx_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_addr  <= r_idx + AW'(1);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_DONE;
            endcase

            if (w_capture) begin
                r_dump_data <= i_arch_rd_data;
                r_dump_idx  <= r_idx;
                r_last      <= w_idx_last;
                r_valid     <= 1'b1;
            end
        end
    end

    assign o_arch_rd_addr = r_addr;
    assign dump.valid     = r_valid;
    assign dump.idx       = r_dump_idx;
    assign dump.data      = r_dump_data;
    assign dump.last      = r_last;
    assign o_cycle_count  = r_cnt;
    assign o_timeout      = r_timeout;
    assign o_done         = r_done;
endmodule

// File: tb/tb_arch_reg_dump_unit.sv
// Directed bench for arch_reg_dump_unit: three builds (RD_LAT 1, 0 and 3) with their own
// regfile models; expected beats come from the bench's register arrays.
module tb_arch_reg_dump_unit;
    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Build A: RD_LAT=1, default watchdog
    logic          rst_a, fin_a, to_a, done_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] rdata_a;
    logic [31:0]   cnt_a;
    logic [DW-1:0] mem_a [N];
    arch_reg_dump_if #(.AW(AW), .DATA_WIDTH(DW)) if_a ();

    arch_reg_dump_unit #(.RD_LAT(1)) u_a (
        .clk(clk), .reset(rst_a), .i_cpu_finish(fin_a), .o_arch_rd_addr(addr_a),
        .i_arch_rd_data(rdata_a), .dump(if_a.master), .o_cycle_count(cnt_a),
        .o_timeout(to_a), .o_done(done_a));

    always_ff @(posedge clk) rdata_a <= mem_a[addr_a];

    // Build B: combinational regfile, 16-cycle watchdog
    logic          rst_b, fin_b, to_b, done_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] rdata_b;
    logic [31:0]   cnt_b;
    logic [DW-1:0] mem_b [N];
    arch_reg_dump_if #(.AW(AW), .DATA_WIDTH(DW)) if_b ();

    arch_reg_dump_unit #(.RD_LAT(0), .TIMEOUT_CYCLES(16)) u_b (
        .clk(clk), .reset(rst_b), .i_cpu_finish(fin_b), .o_arch_rd_addr(addr_b),
        .i_arch_rd_data(rdata_b), .dump(if_b.master), .o_cycle_count(cnt_b),
        .o_timeout(to_b), .o_done(done_b));

    assign rdata_b = mem_b[addr_b];

    // Build C: three-stage regfile read, watchdog disabled
    logic          rst_c, fin_c, to_c, done_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] rdata_c, pipe1_c, pipe2_c;
    logic [31:0]   cnt_c;
    logic [DW-1:0] mem_c [N];
    arch_reg_dump_if #(.AW(AW), .DATA_WIDTH(DW)) if_c ();

    arch_reg_dump_unit #(.RD_LAT(3), .TIMEOUT_CYCLES(0)) u_c (
        .clk(clk), .reset(rst_c), .i_cpu_finish(fin_c), .o_arch_rd_addr(addr_c),
        .i_arch_rd_data(rdata_c), .dump(if_c.master), .o_cycle_count(cnt_c),
        .o_timeout(to_c), .o_done(done_c));

    always_ff @(posedge clk) begin
        pipe1_c <= mem_c[addr_c];
        pipe2_c <= pipe1_c;
        rdata_c <= pipe2_c;
    end

    int  w;
    int  nb, nc;
    logic stall_b, stall_c;

    initial begin
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'(i * 4 + 'h100);
            mem_b[i] = 32'hA5A5_0000 ^ 32'(i * 32'h0101_0101);
            mem_c[i] = $urandom;
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        fin_a = 1'b0; fin_b = 1'b0; fin_c = 1'b0;
        if_a.ready = 1'b0; if_b.ready = 1'b0; if_c.ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid", if_a.valid, 0);
        chk("rst_idx",   if_a.idx, 0);
        chk("rst_data",  if_a.data, 0);
        chk("rst_last",  if_a.last, 0);
        chk("rst_addr",  addr_a, 0);
        chk("rst_cnt",   cnt_a, 0);
        chk("rst_to",    to_a, 0);
        chk("rst_done",  done_a, 0);

        // 40 run cycles, then finish; full dump with a 10-cycle stall on idx 5
        rst_a = 1'b0;
        if_a.ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("a_cnt_run", cnt_a, 40);
        chk("a_valid_run", if_a.valid, 0);
        fin_a = 1'b1;
        for (int k = 0; k < N; k++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!if_a.valid && w < 20);
            chk($sformatf("a_gap[%0d]", k), w, 3);
            chk($sformatf("a_idx[%0d]", k), if_a.idx, k);
            chk($sformatf("a_data[%0d]", k), if_a.data, mem_a[k]);
            chk($sformatf("a_last[%0d]", k), if_a.last, (k == N - 1));
            if (k == 5) begin
                if_a.ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("a_stall_valid", if_a.valid, 1);
                    chk("a_stall_idx", if_a.idx, 5);
                    chk("a_stall_data", if_a.data, mem_a[5]);
                end
                if_a.ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("a_done", done_a, 1);
        chk("a_valid_done", if_a.valid, 0);
        chk("a_to", to_a, 0);
        chk("a_cnt_final", cnt_a, 40);
        fin_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_done_hold", done_a, 1);
        chk("a_cnt_hold", cnt_a, 40);
        chk("a_valid_hold", if_a.valid, 0);

        // Restart, finish after 5 cycles, reset during beat 12, then a fresh dump
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        fin_a = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!if_a.valid && w < 20);
            chk($sformatf("r_idx[%0d]", k), if_a.idx, k);
            chk($sformatf("r_data[%0d]", k), if_a.data, mem_a[k]);
        end
        chk("r_cnt", cnt_a, 5);
        rst_a = 1'b1;
        @(negedge clk);
        chk("r_valid0", if_a.valid, 0);
        chk("r_idx0",   if_a.idx, 0);
        chk("r_data0",  if_a.data, 0);
        chk("r_last0",  if_a.last, 0);
        chk("r_addr0",  addr_a, 0);
        chk("r_cnt0",   cnt_a, 0);
        chk("r_done0",  done_a, 0);
        rst_a = 1'b0;
        for (int k = 0; k < N; k++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!if_a.valid && w < 20);
            chk($sformatf("f_gap[%0d]", k), w, 3);
            chk($sformatf("f_idx[%0d]", k), if_a.idx, k);
            chk($sformatf("f_data[%0d]", k), if_a.data, mem_a[k]);
        end
        @(negedge clk);
        chk("f_done", done_a, 1);
        chk("f_cnt", cnt_a, 0);

        // Watchdog on B, late finish on C, then both drain under random ready
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (7) @(negedge clk);
        chk("c_cnt_run", cnt_c, 7);
        fin_c = 1'b1;
        repeat (8) @(negedge clk);
        chk("b_cnt_pre", cnt_b, 15);
        chk("b_to_pre", to_b, 0);
        @(negedge clk);
        chk("b_to_fire", to_b, 1);
        chk("b_cnt_to", cnt_b, 15);
        chk("c_cnt_frozen", cnt_c, 7);
        chk("c_to", to_c, 0);

        nb = 0; nc = 0; stall_b = 1'b0; stall_c = 1'b0;
        for (int cyc = 0; cyc < 3000 && (nb < N || nc < N); cyc++) begin
            @(negedge clk);
            if (stall_b) begin
                chk("b_hold_valid", if_b.valid, 1);
                chk("b_hold_idx", if_b.idx, nb);
                chk("b_hold_data", if_b.data, mem_b[nb]);
            end
            if (stall_c) begin
                chk("c_hold_valid", if_c.valid, 1);
                chk("c_hold_idx", if_c.idx, nc);
                chk("c_hold_data", if_c.data, mem_c[nc]);
            end
            if_b.ready = 1'($urandom_range(0, 1));
            if_c.ready = 1'($urandom_range(0, 1));
            if (if_b.valid && if_b.ready) begin
                if (nb < N) begin
                    chk($sformatf("b_idx[%0d]", nb), if_b.idx, nb);
                    chk($sformatf("b_data[%0d]", nb), if_b.data, mem_b[nb]);
                    chk($sformatf("b_last[%0d]", nb), if_b.last, (nb == N - 1));
                end else begin
                    chk("b_extra_beat", 1, 0);
                end
                nb++;
            end
            if (if_c.valid && if_c.ready) begin
                if (nc < N) begin
                    chk($sformatf("c_idx[%0d]", nc), if_c.idx, nc);
                    chk($sformatf("c_data[%0d]", nc), if_c.data, mem_c[nc]);
                    chk($sformatf("c_last[%0d]", nc), if_c.last, (nc == N - 1));
                end else begin
                    chk("c_extra_beat", 1, 0);
                end
                nc++;
            end
            stall_b = if_b.valid && !if_b.ready && (nb < N);
            stall_c = if_c.valid && !if_c.ready && (nc < N);
        end
        chk("b_beats", nb, N);
        chk("c_beats", nc, N);
        if_b.ready = 1'b1;
        if_c.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_done", done_b, 1);
        chk("b_to_hold", to_b, 1);
        chk("b_cnt_hold", cnt_b, 15);
        chk("b_valid_done", if_b.valid, 0);
        chk("c_done", done_c, 1);
        chk("c_to_hold", to_c, 0);
        chk("c_cnt_hold", cnt_c, 7);
        chk("c_valid_done", if_c.valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
